// File: rtl/riscv_pkg.sv
// Shared encodings for the memory-side stage: funct3 access sizes,
// the access FSM state encoding and the reset value of the IR.
package riscv_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (same low bits as the signed loads)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit bus: store strobe/replication and
// legality checks on the request side, load extraction/extension on
// the response side. Purely combinational.
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [2:0]  st_funct3,
  input  logic        st_is_write,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  output logic        req_legal,
  output logic        req_misaligned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store strobes and lane-replicated write data
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = st_data;
    case (st_funct3)
      F3_SB: begin
        st_wstrb = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_SH: begin
        st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      F3_SW:   st_wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Supported sizes per direction; unsigned variants exist only for loads
  always_comb begin
    req_legal = 1'b0;
    case (st_funct3)
      F3_LB, F3_LH, F3_LW: req_legal = 1'b1;
      F3_LBU, F3_LHU:      req_legal = !st_is_write;
      default:             req_legal = 1'b0;
    endcase
  end

  // Natural alignment: halves on even bytes, words on word boundaries
  always_comb begin
    req_misaligned = 1'b0;
    case (st_funct3[1:0])
      2'b01:   req_misaligned = st_addr_lo[0];
      2'b10:   req_misaligned = |st_addr_lo;
      default: req_misaligned = 1'b0;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend
  assign lane_sh = rdata >> {ld_addr_lo, 3'b000};
  assign ld_byte = lane_sh[7:0];
  assign ld_half = lane_sh[15:0];

  // Load extraction with sign/zero extension
  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle core: runs one valid/ready access
// on the unified I/D bus per control strobe, holds IR and MDR, and
// stalls the control stage through o_busy. Faults are sticky to reset.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_i_or_d,
  input  logic            i_ir_write,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_alu_out,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_instr,
  output logic [6:0]      o_opcode,
  output logic [XLEN-1:0] o_mdr,
  output logic            o_busy,
  output logic            o_fault,
  output logic            o_bus_valid,
  output logic [XLEN-1:0] o_bus_addr,
  output logic            o_bus_we,
  output logic [3:0]      o_bus_wstrb,
  output logic [XLEN-1:0] o_bus_wdata,
  input  logic            i_bus_ready,
  input  logic [XLEN-1:0] i_bus_rdata,
  input  logic            i_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  mau_state_e      state;
  logic [CW-1:0]   tmo_cnt;
  logic [2:0]      cap_f3;
  logic [1:0]      cap_lo;
  logic            cap_irw;

  logic            start;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_f3;
  logic [3:0]      st_wstrb;
  logic [31:0]     st_wdata;
  logic            req_legal;
  logic            req_misaligned;
  logic [31:0]     ld_data;
  logic            req_bad;

  assign start    = i_mem_read | i_mem_write;
  assign req_addr = i_i_or_d ? i_alu_out : i_pc;
  // Fetches ignore funct3: an instruction is always a full word
  assign req_f3   = i_i_or_d ? i_funct3 : F3_LW;
  assign req_bad  = (i_mem_read & i_mem_write) | req_misaligned | !req_legal;

  mem_lane_align u_align (
    .st_addr_lo     (req_addr[1:0]),
    .st_funct3      (req_f3),
    .st_is_write    (i_mem_write),
    .st_data        (i_store_data),
    .st_wstrb       (st_wstrb),
    .st_wdata       (st_wdata),
    .req_legal      (req_legal),
    .req_misaligned (req_misaligned),
    .ld_addr_lo     (cap_lo),
    .ld_funct3      (cap_f3),
    .rdata          (i_bus_rdata),
    .ld_data        (ld_data)
  );

  assign o_opcode = o_instr[6:0];
  assign o_fault  = (state == ST_FAULT);
  // Stall as soon as a strobe is seen so control holds through the access
  assign o_busy   = ((state == ST_IDLE) & start) | (state == ST_REQ) | (state == ST_FAULT);

  // Access FSM with registered bus request, IR/MDR and timeout counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      o_instr     <= NOP_INSTR;
      o_mdr       <= '0;
      o_bus_valid <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_we    <= 1'b0;
      o_bus_wstrb <= 4'b0000;
      o_bus_wdata <= '0;
      cap_f3      <= 3'b000;
      cap_lo      <= 2'b00;
      cap_irw     <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            o_bus_addr  <= {req_addr[XLEN-1:2], 2'b00};
            o_bus_we    <= i_mem_write;
            o_bus_wstrb <= i_mem_write ? st_wstrb : 4'b0000;
            o_bus_wdata <= i_mem_write ? st_wdata : '0;
            cap_f3      <= req_f3;
            cap_lo      <= req_addr[1:0];
            cap_irw     <= i_ir_write;
            tmo_cnt     <= '0;
            if (req_bad) begin
              state <= ST_FAULT;
            end else begin
              state       <= ST_REQ;
              o_bus_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (i_bus_ready) begin
            o_bus_valid <= 1'b0;
            if (i_bus_err) begin
              state <= ST_FAULT;
            end else begin
              state <= ST_DONE;
              if (!o_bus_we) begin
                o_mdr <= ld_data;
                if (cap_irw) o_instr <= i_bus_rdata;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            o_bus_valid <= 1'b0;
            state       <= ST_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // Strobes seen here belong to the access that just finished
        ST_DONE: state <= ST_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus
// hand-written sequences for faults, timeout and mid-access reset.
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_mem_read = 1'b0, i_mem_write = 1'b0, i_i_or_d = 1'b0, i_ir_write = 1'b0;
  logic [31:0] i_pc = '0, i_alu_out = '0, i_store_data = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] o_instr, o_mdr, o_bus_addr, o_bus_wdata;
  logic [6:0]  o_opcode;
  logic        o_busy, o_fault, o_bus_valid, o_bus_we;
  logic [3:0]  o_bus_wstrb;
  logic        i_bus_ready = 1'b0, i_bus_err = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.XLEN(32), .TIMEOUT(255)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_i_or_d(i_i_or_d), .i_ir_write(i_ir_write),
    .i_pc(i_pc), .i_alu_out(i_alu_out), .i_store_data(i_store_data),
    .i_funct3(i_funct3),
    .o_instr(o_instr), .o_opcode(o_opcode), .o_mdr(o_mdr),
    .o_busy(o_busy), .o_fault(o_fault),
    .o_bus_valid(o_bus_valid), .o_bus_addr(o_bus_addr), .o_bus_we(o_bus_we),
    .o_bus_wstrb(o_bus_wstrb), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd, wr, iod, irw;
    logic [31:0] pc, alu, sdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          wait_cyc;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata, e_mdr, e_instr;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_bus_ready = 1'b0; i_bus_err = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic drive_strobe(input logic rd, input logic wr, input logic iod, input logic irw,
                              input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] sdata, input logic [2:0] f3);
    @(negedge i_clk);
    i_mem_read = rd; i_mem_write = wr; i_i_or_d = iod; i_ir_write = irw;
    i_pc = pc; i_alu_out = alu; i_store_data = sdata; i_funct3 = f3;
  endtask

  // One access from the table: capture, wait states, handshake, DONE, IDLE
  task automatic run_vec(input int idx, input vec_t v);
    int nvalid;
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive_strobe(v.rd, v.wr, v.iod, v.irw, v.pc, v.alu, v.sdata, v.f3);
    #1 chk({tag, " busy_at_strobe"}, {31'b0, o_busy}, 32'd1);
    @(negedge i_clk);
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    chk({tag, " addr"}, o_bus_addr, v.e_addr);
    chk({tag, " we"}, {31'b0, o_bus_we}, {31'b0, v.e_we});
    chk({tag, " wstrb"}, {28'b0, o_bus_wstrb}, {28'b0, v.e_wstrb});
    if (v.wr) chk({tag, " wdata"}, o_bus_wdata, v.e_wdata);
    nvalid = 0;
    for (int w = 0; w <= v.wait_cyc; w++) begin
      if (w == v.wait_cyc) begin
        i_bus_ready = 1'b1; i_bus_rdata = v.rdata; i_bus_err = 1'b0;
      end
      if (o_bus_valid) nvalid++;
      if (!o_busy) chk({tag, " busy_in_req"}, {31'b0, o_busy}, 32'd1);
      @(negedge i_clk);
    end
    i_bus_ready = 1'b0;
    chk({tag, " valid_cycles"}, nvalid, v.wait_cyc + 1);
    chk({tag, " done_busy"}, {31'b0, o_busy}, 32'd0);
    chk({tag, " done_valid"}, {31'b0, o_bus_valid}, 32'd0);
    chk({tag, " mdr"}, o_mdr, v.e_mdr);
    chk({tag, " instr"}, o_instr, v.e_instr);
    chk({tag, " opcode"}, {25'b0, o_opcode}, {25'b0, v.e_instr[6:0]});
    chk({tag, " fault"}, {31'b0, o_fault}, 32'd0);
  endtask

  // Request rejected in IDLE: fault next cycle, bus never requested
  task automatic idle_fault(input string name, input logic rd, input logic wr,
                            input logic [31:0] alu, input logic [2:0] f3);
    int saw_valid;
    do_reset();
    drive_strobe(rd, wr, 1'b1, 1'b0, 32'h0, alu, 32'h1234_5678, f3);
    @(negedge i_clk);
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    chk({name, " fault"}, {31'b0, o_fault}, 32'd1);
    saw_valid = 0;
    for (int k = 0; k < 4; k++) begin
      if (o_bus_valid) saw_valid = 1;
      @(negedge i_clk);
    end
    chk({name, " no_valid"}, saw_valid, 0);
    chk({name, " busy"}, {31'b0, o_busy}, 32'd1);
    chk({name, " fault_sticky"}, {31'b0, o_fault}, 32'd1);
    chk({name, " instr"}, o_instr, 32'h0000_0013);
  endtask

  initial begin
    int n;
    //          rd   wr   iod  irw  pc            alu           sdata         f3      rdata         w  e_addr        we   wstrb    e_wdata       e_mdr         e_instr
    vt[0]  = '{1'b1,1'b0,1'b0,1'b1,32'h0000_0100,32'h0,        32'h0,        3'b000,32'h00A0_0093,3, 32'h0000_0100,1'b0,4'b0000,32'h0,        32'h00A0_0093,32'h00A0_0093};
    vt[1]  = '{1'b1,1'b0,1'b1,1'b0,32'h0000_03FC,32'h0000_0203,32'h0,        3'b000,32'h80FF_1234,0, 32'h0000_0200,1'b0,4'b0000,32'h0,        32'hFFFF_FF80,32'h00A0_0093};
    vt[2]  = '{1'b1,1'b0,1'b1,1'b0,32'h0000_03FC,32'h0000_0203,32'h0,        3'b100,32'h80FF_1234,0, 32'h0000_0200,1'b0,4'b0000,32'h0,        32'h0000_0080,32'h00A0_0093};
    vt[3]  = '{1'b0,1'b1,1'b1,1'b0,32'h0000_03FC,32'h0000_0206,32'hDEAD_BEEF,3'b001,32'h0,        1, 32'h0000_0204,1'b1,4'b1100,32'hBEEF_BEEF,32'h0000_0080,32'h00A0_0093};
    vt[4]  = '{1'b1,1'b0,1'b1,1'b0,32'h0000_03FC,32'h0000_0202,32'h0,        3'b001,32'h80FF_1234,0, 32'h0000_0200,1'b0,4'b0000,32'h0,        32'hFFFF_80FF,32'h00A0_0093};
    vt[5]  = '{1'b1,1'b0,1'b1,1'b0,32'h0000_03FC,32'h0000_0200,32'h0,        3'b101,32'h80FF_1234,0, 32'h0000_0200,1'b0,4'b0000,32'h0,        32'h0000_1234,32'h00A0_0093};
    vt[6]  = '{1'b1,1'b0,1'b1,1'b0,32'h0000_03FC,32'h0000_0204,32'h0,        3'b010,32'hCAFE_F00D,2, 32'h0000_0204,1'b0,4'b0000,32'h0,        32'hCAFE_F00D,32'h00A0_0093};
    vt[7]  = '{1'b0,1'b1,1'b1,1'b0,32'h0000_03FC,32'h0000_0201,32'h1234_56A5,3'b000,32'h0,        0, 32'h0000_0200,1'b1,4'b0010,32'hA5A5_A5A5,32'hCAFE_F00D,32'h00A0_0093};
    vt[8]  = '{1'b0,1'b1,1'b1,1'b0,32'h0000_03FC,32'h0000_0208,32'h0102_0304,3'b010,32'h0,        1, 32'h0000_0208,1'b1,4'b1111,32'h0102_0304,32'hCAFE_F00D,32'h00A0_0093};
    vt[9]  = '{1'b1,1'b0,1'b1,1'b0,32'h0000_03FC,32'h0000_0202,32'h0,        3'b000,32'h127F_0000,0, 32'h0000_0200,1'b0,4'b0000,32'h0,        32'h0000_007F,32'h00A0_0093};
    vt[10] = '{1'b1,1'b0,1'b0,1'b1,32'h0000_0104,32'h0000_0203,32'h0,        3'b000,32'h00B0_0113,0, 32'h0000_0104,1'b0,4'b0000,32'h0,        32'h00B0_0113,32'h00B0_0113};
    vt[11] = '{1'b1,1'b0,1'b0,1'b0,32'h0000_0108,32'h0,        32'h0,        3'b000,32'h00C0_006F,0, 32'h0000_0108,1'b0,4'b0000,32'h0,        32'h00C0_006F,32'h00B0_0113};
    vt[12] = '{1'b0,1'b1,1'b1,1'b0,32'h0000_03FC,32'h0000_0200,32'h0000_CAFE,3'b001,32'h0,        0, 32'h0000_0200,1'b1,4'b0011,32'hCAFE_CAFE,32'h00C0_006F,32'h00B0_0113};

    do_reset();
    chk("rst instr", o_instr, 32'h0000_0013);
    chk("rst opcode", {25'b0, o_opcode}, 32'h13);
    chk("rst mdr", o_mdr, 32'h0);
    chk("rst fault", {31'b0, o_fault}, 32'd0);
    chk("rst valid", {31'b0, o_bus_valid}, 32'd0);
    chk("rst busy", {31'b0, o_busy}, 32'd0);
    chk("rst addr", o_bus_addr, 32'h0);
    chk("rst wstrb", {28'b0, o_bus_wstrb}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      run_vec(i, vt[i]);
      @(negedge i_clk);
      chk($sformatf("vec%0d idle_busy", i), {31'b0, o_busy}, 32'd0);
    end

    idle_fault("misaligned_lw", 1'b1, 1'b0, 32'h0000_0101, 3'b010);
    idle_fault("misaligned_lh", 1'b1, 1'b0, 32'h0000_0203, 3'b001);
    idle_fault("both_strobes", 1'b1, 1'b1, 32'h0000_0200, 3'b010);
    idle_fault("bad_load_f3", 1'b1, 1'b0, 32'h0000_0200, 3'b011);
    idle_fault("bad_store_f3", 1'b0, 1'b1, 32'h0000_0200, 3'b100);

    // Timeout: ready never comes, fault after exactly 255 REQ cycles
    do_reset();
    drive_strobe(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0300, 32'h0, 3'b010);
    @(negedge i_clk);
    i_mem_read = 1'b0;
    n = 0;
    while (o_bus_valid && n < 400) begin
      n++;
      @(negedge i_clk);
    end
    chk("timeout req_cycles", n, 255);
    chk("timeout fault", {31'b0, o_fault}, 32'd1);
    chk("timeout busy", {31'b0, o_busy}, 32'd1);

    // Bus error: fault, IR and MDR keep the previous access results
    do_reset();
    run_vec(100, vt[0]);
    @(negedge i_clk);
    drive_strobe(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0108, 32'h0, 32'h0, 3'b000);
    @(negedge i_clk);
    i_mem_read = 1'b0;
    i_bus_ready = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    i_bus_ready = 1'b0; i_bus_err = 1'b0;
    chk("err fault", {31'b0, o_fault}, 32'd1);
    chk("err valid", {31'b0, o_bus_valid}, 32'd0);
    chk("err instr", o_instr, 32'h00A0_0093);
    chk("err mdr", o_mdr, 32'h00A0_0093);

    // Reset while a request is outstanding, then a clean fetch
    do_reset();
    drive_strobe(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 3'b000);
    @(negedge i_clk);
    i_mem_read = 1'b0;
    chk("midrst valid_before", {31'b0, o_bus_valid}, 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("midrst valid", {31'b0, o_bus_valid}, 32'd0);
    chk("midrst instr", o_instr, 32'h0000_0013);
    chk("midrst busy", {31'b0, o_busy}, 32'd0);
    chk("midrst fault", {31'b0, o_fault}, 32'd0);
    run_vec(200, vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
